// File: rtl/damage_scheduler.sv
// Hit arbiter and damage pulse shaper for the player health FSM, with invincibility window and death detect.
// Optional sprite blink during invincibility is enabled by defining DAMAGE_BLINK_EN.
module damage_scheduler #(
  parameter int N_SRC       = 4,
  parameter int HOLD_FRAMES = 2,
  parameter int IFRAMES     = 60
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             frame_tick,
  input  logic [N_SRC-1:0] hit_req,
  input  logic [1:0]       health_in,
  output logic             collision_flag,
  output logic [N_SRC-1:0] hit_grant,
  output logic             invincible,
  output logic             game_over,
  output logic [7:0]       hit_count,
  output logic             blink
);

  localparam int MAXF = (HOLD_FRAMES > IFRAMES) ? HOLD_FRAMES : IFRAMES;
  localparam int CW   = $clog2(MAXF + 1);
  localparam int PW   = $clog2(N_SRC);

  typedef enum logic [1:0] {IDLE, HIT, IFRAME, DEAD} state_t;

  state_t           state;
  logic [CW-1:0]    frm_cnt;
  logic [CW-1:0]    frm_inc;
  logic [PW-1:0]    rr_ptr;
  logic [PW-1:0]    win_idx;
  logic [PW-1:0]    rr_next;
  logic [N_SRC-1:0] win_oh;
  logic             win_found;
  logic             dead_now;
  logic             hold_done;
  logic             ifr_done;
  int               j;

  // Round-robin search starting at rr_ptr, wrapping past the top source.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    j         = 0;
    for (int i = 0; i < N_SRC; i++) begin
      j = int'(rr_ptr) + i;
      if (j >= N_SRC) j = j - N_SRC;
      if (!win_found && hit_req[j]) begin
        win_found = 1'b1;
        win_idx   = PW'(j);
      end
    end
    win_oh          = '0;
    win_oh[win_idx] = 1'b1;
    rr_next         = (win_idx == PW'(N_SRC - 1)) ? '0 : win_idx + 1'b1;
  end

  assign frm_inc   = frm_cnt + 1'b1;
  assign dead_now  = (health_in == 2'd0);
  assign hold_done = frame_tick && (frm_inc == CW'(HOLD_FRAMES));
  assign ifr_done  = frame_tick && (frm_inc == CW'(IFRAMES));

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state          <= IDLE;
      rr_ptr         <= '0;
      frm_cnt        <= '0;
      collision_flag <= 1'b0;
      hit_grant      <= '0;
      invincible     <= 1'b0;
      game_over      <= 1'b0;
      hit_count      <= 8'd0;
    end else begin
      hit_grant <= '0;
      case (state)
        IDLE: begin
          // Health already at zero beats any pending hit.
          if (dead_now) begin
            state     <= DEAD;
            game_over <= 1'b1;
          end else if (win_found) begin
            state          <= HIT;
            hit_grant      <= win_oh;
            collision_flag <= 1'b1;
            invincible     <= 1'b1;
            frm_cnt        <= '0;
            rr_ptr         <= rr_next;
            if (hit_count != 8'hFF) hit_count <= hit_count + 8'd1;
          end
        end
        HIT: begin
          if (hold_done) begin
            state          <= IFRAME;
            collision_flag <= 1'b0;
            frm_cnt        <= '0;
          end else if (frame_tick) begin
            frm_cnt <= frm_inc;
          end
        end
        IFRAME: begin
          if (dead_now) begin
            state      <= DEAD;
            invincible <= 1'b0;
            game_over  <= 1'b1;
          end else if (ifr_done) begin
            state      <= IDLE;
            invincible <= 1'b0;
            frm_cnt    <= '0;
          end else if (frame_tick) begin
            frm_cnt <= frm_inc;
          end
        end
        default: begin
          collision_flag <= 1'b0;
          invincible     <= 1'b0;
          game_over      <= 1'b1;
        end
      endcase
    end
  end

`ifdef DAMAGE_BLINK_EN
  logic [1:0] blk_cnt;
  logic       stay_ifr;

  assign stay_ifr = (state == IFRAME) && !dead_now && !ifr_done;

  // Toggle on every 4th frame tick while invincibility continues.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      blink   <= 1'b0;
      blk_cnt <= 2'd0;
    end else if (!stay_ifr) begin
      blink   <= 1'b0;
      blk_cnt <= 2'd0;
    end else if (frame_tick) begin
      blk_cnt <= blk_cnt + 2'd1;
      if (blk_cnt == 2'd3) blink <= ~blink;
    end
  end
`else
  assign blink = 1'b0;
`endif

endmodule

// File: tb/tb_damage_scheduler.sv
// Directed bench for damage_scheduler: grant/flag timing, invincibility window, rotation, death, reset, blink.
module tb_damage_scheduler;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       frame_tick;
  logic [3:0] hit_req;
  logic [1:0] health_in;
  logic       collision_flag;
  logic [3:0] hit_grant;
  logic       invincible;
  logic       game_over;
  logic [7:0] hit_count;
  logic       blink;

  int n_cmp = 0;
  int n_err = 0;
  logic [3:0] any_g;

  damage_scheduler #(.N_SRC(4), .HOLD_FRAMES(2), .IFRAMES(60)) dut (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .hit_req(hit_req),
    .health_in(health_in), .collision_flag(collision_flag), .hit_grant(hit_grant),
    .invincible(invincible), .game_over(game_over), .hit_count(hit_count), .blink(blink)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic frame();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step();
  endtask

  // Expected blink after k frame ticks spent in IFRAME (k < 60).
  function automatic logic blink_exp(input int k);
`ifdef DAMAGE_BLINK_EN
    return ((k / 4) % 2) == 1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic do_reset();
    Reset = 1'b1;
    step();
    step();
    Reset = 1'b0;
    step();
  endtask

  initial begin
    Reset = 1'b1; frame_tick = 1'b0; hit_req = 4'b0; health_in = 2'd3;
    #12;
    chk("rst_flag", {31'b0, collision_flag}, 32'd0);
    chk("rst_grant", {28'b0, hit_grant}, 32'd0);
    chk("rst_inv", {31'b0, invincible}, 32'd0);
    chk("rst_go", {31'b0, game_over}, 32'd0);
    chk("rst_cnt", {24'b0, hit_count}, 32'd0);
    chk("rst_blink", {31'b0, blink}, 32'd0);
    step();
    Reset = 1'b0;
    step();

    // Single hit from source 2, flag held for two frames
    hit_req = 4'b0100;
    step();
    chk("t1_grant", {28'b0, hit_grant}, 32'h4);
    chk("t1_flag", {31'b0, collision_flag}, 32'd1);
    chk("t1_cnt", {24'b0, hit_count}, 32'd1);
    chk("t1_inv", {31'b0, invincible}, 32'd1);
    hit_req = 4'b0;
    step();
    chk("t1_pulse", {28'b0, hit_grant}, 32'h0);
    frame();
    chk("t1_flag_f1", {31'b0, collision_flag}, 32'd1);
    frame();
    chk("t1_flag_f2", {31'b0, collision_flag}, 32'd0);
    chk("t1_inv_ifr", {31'b0, invincible}, 32'd1);

    // Requests dropped during the invincibility window
    hit_req = 4'b0001;
    any_g = 4'b0;
    for (int f = 1; f <= 59; f++) begin
      frame();
      any_g |= hit_grant;
    end
    chk("t2_no_grant", {28'b0, any_g}, 32'h0);
    chk("t2_inv_59", {31'b0, invincible}, 32'd1);
    frame_tick = 1'b1;
    step();
    chk("t2_exit_inv", {31'b0, invincible}, 32'd0);
    chk("t2_exit_grant", {28'b0, hit_grant}, 32'h0);
    frame_tick = 1'b0;
    step();
    chk("t2_grant", {28'b0, hit_grant}, 32'h1);
    chk("t2_flag", {31'b0, collision_flag}, 32'd1);
    chk("t2_cnt", {24'b0, hit_count}, 32'd2);

    // Asynchronous reset in the middle of HIT
    Reset = 1'b1;
    #1;
    chk("t5_flag", {31'b0, collision_flag}, 32'd0);
    chk("t5_inv", {31'b0, invincible}, 32'd0);
    chk("t5_cnt", {24'b0, hit_count}, 32'd0);
    chk("t5_go", {31'b0, game_over}, 32'd0);
    hit_req = 4'b0;
    step();
    step();
    Reset = 1'b0;
    step();
    chk("t5_idle_inv", {31'b0, invincible}, 32'd0);
    chk("t5_idle_flag", {31'b0, collision_flag}, 32'd0);

    // Round-robin rotation with all sources requesting
    hit_req = 4'b1111;
    step();
    chk("t3_grant0", {28'b0, hit_grant}, 32'h1);
    chk("t3_cnt0", {24'b0, hit_count}, 32'd1);
    for (int r = 1; r <= 4; r++) begin
      for (int f = 1; f <= 62; f++) begin
        frame();
        if (r == 1) begin
          if (f == 2) chk("t3_flag_fall", {31'b0, collision_flag}, 32'd0);
          chk($sformatf("t6_blink_f%0d", f), {31'b0, blink}, {31'b0,
              ((f <= 2) || (f >= 62)) ? 1'b0 : blink_exp(f - 2)});
        end
      end
      chk($sformatf("t3_grant%0d", r), {28'b0, hit_grant}, 32'(4'b0001 << (r % 4)));
      chk($sformatf("t3_cnt%0d", r), {24'b0, hit_count}, 32'(r + 1));
    end
    hit_req = 4'b0;

    // Death after the third hit, health falling to zero in IFRAME
    do_reset();
    health_in = 2'd3;
    hit_req = 4'b0010;
    step();
    chk("t4_grant1", {28'b0, hit_grant}, 32'h2);
    health_in = 2'd2;
    for (int f = 1; f <= 62; f++) frame();
    chk("t4_grant2", {28'b0, hit_grant}, 32'h2);
    health_in = 2'd1;
    for (int f = 1; f <= 62; f++) frame();
    chk("t4_grant3", {28'b0, hit_grant}, 32'h2);
    chk("t4_cnt3", {24'b0, hit_count}, 32'd3);
    frame();
    frame();
    chk("t4_ifr_inv", {31'b0, invincible}, 32'd1);
    chk("t4_ifr_go", {31'b0, game_over}, 32'd0);
    health_in = 2'd0;
    step();
    chk("t4_go", {31'b0, game_over}, 32'd1);
    chk("t4_inv", {31'b0, invincible}, 32'd0);
    hit_req = 4'b1111;
    any_g = 4'b0;
    for (int c = 0; c < 10; c++) begin
      if (c % 3 == 0) frame(); else step();
      any_g |= hit_grant;
    end
    chk("t4_dead_grant", {28'b0, any_g}, 32'h0);
    chk("t4_dead_cnt", {24'b0, hit_count}, 32'd3);
    chk("t4_dead_flag", {31'b0, collision_flag}, 32'd0);
    chk("t4_dead_go", {31'b0, game_over}, 32'd1);

    // Zero health in IDLE beats a simultaneous hit request
    hit_req = 4'b0;
    health_in = 2'd3;
    Reset = 1'b1;
    step();
    step();
    health_in = 2'd0;
    hit_req = 4'b0001;
    Reset = 1'b0;
    step();
    chk("idle_dead_go", {31'b0, game_over}, 32'd1);
    chk("idle_dead_grant", {28'b0, hit_grant}, 32'h0);
    chk("idle_dead_cnt", {24'b0, hit_count}, 32'd0);
    chk("idle_dead_flag", {31'b0, collision_flag}, 32'd0);
    chk("idle_dead_blink", {31'b0, blink}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
